// File: rtl/npc_bus_pkg.sv
// Shared types for the memory-bus arbiter: FSM states, owner encoding and
// the tie-break rule used when choosing which requester gets the bus.
package npc_bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_ERR,
        S_DRAIN
    } arb_state_t;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } owner_t;

    // A lone requester always wins. On a tie, either LSU wins outright or
    // the requester that was not served last wins.
    function automatic owner_t pick_owner(
        input logic   ifu_v,
        input logic   lsu_v,
        input logic   lsu_prio,
        input owner_t last
    );
        if (ifu_v && lsu_v) begin
            if (lsu_prio)
                return OWN_LSU;
            return (last == OWN_IFU) ? OWN_LSU : OWN_IFU;
        end
        if (lsu_v)
            return OWN_LSU;
        return OWN_IFU;
    endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// Response-wait counter. Cleared when a request is accepted, counts while
// the arbiter waits for a response, and flags the last allowed wait cycle.
// A TIMEOUT of 0 means the counter never expires.
module bus_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Wait-cycle counter, restarted on every accepted request.
    always_ff @(posedge clk) begin
        if (rst || clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + CW'(1);
    end

    assign expired = (TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the fetch unit and the load/store unit.
// Only one transaction is in flight; the owner keeps the bus from request
// until its response is taken, so responses need no tag. A silent memory
// produces an error response, and any late reply is then swallowed.
module mem_bus_arbiter
    import npc_bus_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LSU_PRIO = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_resp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    output logic                mem_resp_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_resp_err
);

    arb_state_t state, state_next;
    owner_t     owner, last_owner, grant;
    logic       owner_resp_ready;
    logic       req_hs, resp_hs;
    logic       tcnt_en, tcnt_expired;

    assign grant            = pick_owner(ifu_req_valid, lsu_req_valid, (LSU_PRIO != 0), last_owner);
    assign owner_resp_ready = (owner == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;
    assign req_hs           = (state == S_REQ) && mem_req_ready;
    assign resp_hs          = (state == S_RESP) && mem_resp_valid && owner_resp_ready;
    // Stop counting once expired so a held-but-untaken response keeps the flag.
    assign tcnt_en          = (state == S_RESP) && !resp_hs && !tcnt_expired;

    bus_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tcnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (req_hs),
        .enable  (tcnt_en),
        .expired (tcnt_expired)
    );

    // State, current owner and the last-served owner for round-robin ties.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            owner      <= OWN_IFU;
            last_owner <= OWN_IFU;
        end else begin
            state <= state_next;
            if (state == S_IDLE && (ifu_req_valid || lsu_req_valid))
                owner <= grant;
            if (req_hs)
                last_owner <= owner;
        end
    end

    // Next-state logic and the owner-steered request/response muxes.
    always_comb begin
        state_next     = state;
        ifu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        ifu_resp_err   = 1'b0;
        lsu_req_ready  = 1'b0;
        lsu_resp_valid = 1'b0;
        lsu_rdata      = '0;
        lsu_resp_err   = 1'b0;
        mem_req_valid  = 1'b0;
        mem_addr       = '0;
        mem_wen        = 1'b0;
        mem_wdata      = '0;
        mem_wmask      = '0;
        mem_resp_ready = 1'b0;
        case (state)
            S_IDLE: begin
                if (ifu_req_valid || lsu_req_valid)
                    state_next = S_REQ;
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                if (owner == OWN_LSU) begin
                    mem_addr      = lsu_addr;
                    mem_wen       = lsu_wen;
                    mem_wdata     = lsu_wdata;
                    mem_wmask     = lsu_wmask;
                    lsu_req_ready = mem_req_ready;
                end else begin
                    mem_addr      = ifu_addr;
                    ifu_req_ready = mem_req_ready;
                end
                if (mem_req_ready)
                    state_next = S_RESP;
            end
            S_RESP: begin
                if (owner == OWN_LSU) begin
                    lsu_resp_valid = mem_resp_valid;
                    lsu_rdata      = mem_rdata;
                    lsu_resp_err   = mem_resp_err;
                end else begin
                    ifu_resp_valid = mem_resp_valid;
                    ifu_rdata      = mem_rdata;
                    ifu_resp_err   = mem_resp_err;
                end
                mem_resp_ready = owner_resp_ready;
                if (mem_resp_valid && owner_resp_ready)
                    state_next = S_IDLE;
                else if (tcnt_expired && !mem_resp_valid)
                    state_next = S_ERR;
            end
            S_ERR: begin
                if (owner == OWN_LSU) begin
                    lsu_resp_valid = 1'b1;
                    lsu_resp_err   = 1'b1;
                end else begin
                    ifu_resp_valid = 1'b1;
                    ifu_resp_err   = 1'b1;
                end
                if (owner_resp_ready)
                    state_next = S_DRAIN;
            end
            S_DRAIN: begin
                mem_resp_ready = 1'b1;
                if (mem_resp_valid)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one LSU-priority instance with a short
// timeout for the transaction scenarios, one round-robin instance for the
// alternating-grant scenario. Responses are predicted into queues.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // LSU-priority instance
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready, mem_resp_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    // Round-robin instance
    logic        b_ifu_req_valid, b_ifu_req_ready, b_ifu_resp_valid, b_ifu_resp_ready, b_ifu_resp_err;
    logic [31:0] b_ifu_addr, b_ifu_rdata;
    logic        b_lsu_req_valid, b_lsu_req_ready, b_lsu_wen, b_lsu_resp_valid, b_lsu_resp_ready, b_lsu_resp_err;
    logic [31:0] b_lsu_addr, b_lsu_wdata, b_lsu_rdata;
    logic [3:0]  b_lsu_wmask;
    logic        b_mem_req_valid, b_mem_req_ready, b_mem_wen, b_mem_resp_valid, b_mem_resp_ready, b_mem_resp_err;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_mem_wmask;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LSU_PRIO(1), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
    );

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LSU_PRIO(0), .TIMEOUT(8)) dut_rr (
        .clk(clk), .rst(rst),
        .ifu_req_valid(b_ifu_req_valid), .ifu_req_ready(b_ifu_req_ready), .ifu_addr(b_ifu_addr),
        .ifu_resp_valid(b_ifu_resp_valid), .ifu_resp_ready(b_ifu_resp_ready),
        .ifu_rdata(b_ifu_rdata), .ifu_resp_err(b_ifu_resp_err),
        .lsu_req_valid(b_lsu_req_valid), .lsu_req_ready(b_lsu_req_ready), .lsu_addr(b_lsu_addr),
        .lsu_wen(b_lsu_wen), .lsu_wdata(b_lsu_wdata), .lsu_wmask(b_lsu_wmask),
        .lsu_resp_valid(b_lsu_resp_valid), .lsu_resp_ready(b_lsu_resp_ready),
        .lsu_rdata(b_lsu_rdata), .lsu_resp_err(b_lsu_resp_err),
        .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready), .mem_addr(b_mem_addr),
        .mem_wen(b_mem_wen), .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask),
        .mem_resp_valid(b_mem_resp_valid), .mem_resp_ready(b_mem_resp_ready),
        .mem_rdata(b_mem_rdata), .mem_resp_err(b_mem_resp_err)
    );

    typedef struct {
        logic        is_lsu;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        logic        is_lsu;
        logic [31:0] addr;
    } grant_t;

    resp_t  sbq[$];
    grant_t gq[$];
    int     vectors     = 0;
    int     miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one granted transaction through the memory side and checks the
    // request fields and the routed response. Called at negedge+1 with the
    // request already presented.
    task automatic serve(input string tag, input logic is_lsu, input logic [31:0] addr,
                         input logic wen, input logic [31:0] wdata, input logic [3:0] wmask,
                         input logic [31:0] rd, input logic rerr, input int exp_wait);
        int    waited;
        resp_t r;
        resp_t e;
        waited = 0;
        while (!mem_req_valid && waited < 20) begin
            @(negedge clk); #1;
            waited++;
        end
        check({tag, ":wait"}, 64'(waited), 64'(exp_wait));
        if (!mem_req_valid) return;
        check({tag, ":addr"}, 64'(mem_addr), 64'(addr));
        check({tag, ":wen"}, 64'(mem_wen), 64'(wen));
        check({tag, ":wmask"}, 64'(mem_wmask), 64'(wmask));
        if (is_lsu) check({tag, ":wdata"}, 64'(mem_wdata), 64'(wdata));
        check({tag, ":rdy_hold_ifu"}, 64'(ifu_req_ready), 64'(0));
        check({tag, ":rdy_hold_lsu"}, 64'(lsu_req_ready), 64'(0));
        mem_req_ready = 1'b1;
        #1;
        check({tag, ":lsu_req_ready"}, 64'(lsu_req_ready), 64'(is_lsu));
        check({tag, ":ifu_req_ready"}, 64'(ifu_req_ready), 64'(!is_lsu));
        check({tag, ":req_resp_ready"}, 64'(mem_resp_ready), 64'(0));
        r.is_lsu = is_lsu;
        r.rdata  = rd;
        r.err    = rerr;
        sbq.push_back(r);
        @(negedge clk);
        mem_req_ready = 1'b0;
        if (is_lsu) lsu_req_valid = 1'b0;
        else        ifu_req_valid = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = rd;
        mem_resp_err   = rerr;
        #1;
        if (ifu_resp_valid || lsu_resp_valid) begin
            e = sbq.pop_front();
            check({tag, ":lsu_resp_valid"}, 64'(lsu_resp_valid), 64'(e.is_lsu));
            check({tag, ":ifu_resp_valid"}, 64'(ifu_resp_valid), 64'(!e.is_lsu));
            check({tag, ":rdata"}, 64'(e.is_lsu ? lsu_rdata : ifu_rdata), 64'(e.rdata));
            check({tag, ":err"}, 64'(e.is_lsu ? lsu_resp_err : ifu_resp_err), 64'(e.err));
            check({tag, ":mem_resp_ready"}, 64'(mem_resp_ready), 64'(1));
        end else begin
            check({tag, ":resp_seen"}, 64'(0), 64'(1));
        end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        mem_resp_err   = 1'b0;
        #1;
        check({tag, ":idle_ifu_resp"}, 64'(ifu_resp_valid), 64'(0));
        check({tag, ":idle_lsu_resp"}, 64'(lsu_resp_valid), 64'(0));
        check({tag, ":idle_mem_resp_ready"}, 64'(mem_resp_ready), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int    quiet;
        int    cyc;
        resp_t e;
        grant_t g;

        rst = 1'b1;
        ifu_req_valid = 0; ifu_addr = 0; ifu_resp_ready = 1;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0; lsu_resp_ready = 1;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0; mem_resp_err = 0;
        b_ifu_req_valid = 0; b_ifu_addr = 0; b_ifu_resp_ready = 0;
        b_lsu_req_valid = 0; b_lsu_addr = 0; b_lsu_wen = 0; b_lsu_wdata = 0; b_lsu_wmask = 0; b_lsu_resp_ready = 0;
        b_mem_req_ready = 0; b_mem_resp_valid = 0; b_mem_rdata = 0; b_mem_resp_err = 0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst:mem_req_valid", 64'(mem_req_valid), 64'(0));
        check("rst:mem_resp_ready", 64'(mem_resp_ready), 64'(0));
        check("rst:ifu_resp_valid", 64'(ifu_resp_valid), 64'(0));
        check("rst:lsu_resp_valid", 64'(lsu_resp_valid), 64'(0));
        check("rst:mem_addr", 64'(mem_addr), 64'(0));
        check("rst:rdata", 64'({ifu_rdata, lsu_rdata}), 64'(0));
        check("rst:b_mem_req_valid", 64'(b_mem_req_valid), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;

        // 1: IFU read alone
        @(negedge clk);
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        #1;
        check("t1:idle_no_ready", 64'(ifu_req_ready), 64'(0));
        serve("t1", 1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h0000_0413, 1'b0, 1);

        // 2: simultaneous requests, LSU first, IFU one idle cycle later
        @(negedge clk);
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0200;
        #1;
        serve("t2_lsu", 1'b1, 32'h8000_0200, 1'b0, 32'h0, 4'h0, 32'h1111_1111, 1'b0, 1);
        serve("t2_ifu", 1'b0, 32'h8000_0100, 1'b0, 32'h0, 4'h0, 32'h2222_2222, 1'b0, 1);

        // 4: LSU write fields at the handshake
        @(negedge clk);
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0010; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
        #1;
        serve("t4", 1'b1, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'b0011, 32'h0, 1'b0, 1);
        lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;

        // Memory error passes straight through to the owner
        @(negedge clk);
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
        #1;
        serve("terr", 1'b0, 32'h8000_0040, 1'b0, 32'h0, 4'h0, 32'h0000_0BAD, 1'b1, 1);

        // 5: timeout, drain of a late reply, then a normal request
        @(negedge clk);
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0020;
        #1;
        @(negedge clk); #1;
        check("t5:req_valid", 64'(mem_req_valid), 64'(1));
        mem_req_ready = 1'b1;
        e.is_lsu = 1'b1; e.rdata = 32'h0; e.err = 1'b1;
        sbq.push_back(e);
        @(negedge clk);
        mem_req_ready = 1'b0; lsu_req_valid = 1'b0;
        #1;
        quiet = 0;
        while (!lsu_resp_valid && !ifu_resp_valid && quiet < 30) begin
            @(negedge clk); #1;
            quiet++;
        end
        check("t5:wait_cycles", 64'(quiet), 64'(8));
        e = sbq.pop_front();
        check("t5:lsu_resp_valid", 64'(lsu_resp_valid), 64'(e.is_lsu));
        check("t5:ifu_resp_valid", 64'(ifu_resp_valid), 64'(0));
        check("t5:err", 64'(lsu_resp_err), 64'(e.err));
        check("t5:rdata", 64'(lsu_rdata), 64'(e.rdata));
        check("t5:err_mem_resp_ready", 64'(mem_resp_ready), 64'(0));
        @(negedge clk);
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
        #1;
        check("t5:drain_resp_ready", 64'(mem_resp_ready), 64'(1));
        check("t5:drain_lsu_resp", 64'(lsu_resp_valid), 64'(0));
        check("t5:drain_no_grant", 64'(mem_req_valid), 64'(0));
        @(negedge clk); #1;
        check("t5:drain_no_grant2", 64'(mem_req_valid), 64'(0));
        @(negedge clk);
        mem_resp_valid = 1'b1; mem_rdata = 32'h0000_1234;
        #1;
        check("t5:late_discard_lsu", 64'(lsu_resp_valid), 64'(0));
        check("t5:late_discard_ifu", 64'(ifu_resp_valid), 64'(0));
        @(negedge clk);
        mem_resp_valid = 1'b0; mem_rdata = 32'h0;
        #1;
        check("t5:idle_after_drain", 64'(mem_req_valid), 64'(0));
        serve("t5_next", 1'b0, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 32'h0000_0013, 1'b0, 1);

        // 6: reset while waiting for a response
        @(negedge clk);
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0008;
        #1;
        @(negedge clk); #1;
        check("t6:req_valid", 64'(mem_req_valid), 64'(1));
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0; ifu_req_valid = 1'b0;
        #1;
        check("t6:in_resp", 64'(mem_resp_ready), 64'(1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6:mem_req_valid", 64'(mem_req_valid), 64'(0));
        check("t6:mem_resp_ready", 64'(mem_resp_ready), 64'(0));
        check("t6:resp_valid", 64'({ifu_resp_valid, lsu_resp_valid}), 64'(0));
        check("t6:req_ready", 64'({ifu_req_ready, lsu_req_ready}), 64'(0));
        check("t6:mem_addr", 64'(mem_addr), 64'(0));
        check("t6:rdata_err", 64'({ifu_rdata, ifu_resp_err}), 64'(0));
        @(negedge clk);
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0030;
        #1;
        serve("t6_next", 1'b1, 32'h8000_0030, 1'b0, 32'h0, 4'h0, 32'hCAFE_0001, 1'b0, 1);
        check("sb:empty", 64'(sbq.size()), 64'(0));

        // 3: round-robin with both requesters always valid
        @(negedge clk);
        b_ifu_req_valid = 1'b1; b_ifu_addr = 32'h0000_1000;
        b_lsu_req_valid = 1'b1; b_lsu_addr = 32'h0000_2000;
        b_mem_req_ready = 1'b1; b_mem_resp_valid = 1'b1; b_mem_rdata = 32'h55;
        b_ifu_resp_ready = 1'b1; b_lsu_resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            g.is_lsu = (i % 2 == 0);
            g.addr   = g.is_lsu ? 32'h0000_2000 : 32'h0000_1000;
            gq.push_back(g);
        end
        #1;
        cyc = 0;
        while (gq.size() != 0 && cyc < 40) begin
            if (b_mem_req_valid) begin
                g = gq.pop_front();
                check("t3:lsu_grant", 64'(b_lsu_req_ready), 64'(g.is_lsu));
                check("t3:ifu_grant", 64'(b_ifu_req_ready), 64'(!g.is_lsu));
                check("t3:addr", 64'(b_mem_addr), 64'(g.addr));
            end
            @(negedge clk); #1;
            cyc++;
        end
        check("t3:all_grants", 64'(gq.size()), 64'(0));
        b_ifu_req_valid = 1'b0; b_lsu_req_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
